lsu_memop_unit: RTL and testbench



---
 rtl/lsu_memop_unit_pkg.sv | 28 ++
 rtl/lsu_lane_align.sv | 30 +++
 rtl/lsu_memop_unit.sv | 127 ++++++++++++
 tb/tb_lsu_memop_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_memop_unit_pkg.sv
// lsu_memop_unit_pkg: memop codes, FSM states, access sizes and lane helpers
// shared by the load/store unit and its lane aligner.
package lsu_memop_unit_pkg;

    localparam logic [2:0] MOP_B  = 3'b000;
    localparam logic [2:0] MOP_H  = 3'b001;
    localparam logic [2:0] MOP_W  = 3'b010;
    localparam logic [2:0] MOP_BU = 3'b100;
    localparam logic [2:0] MOP_HU = 3'b101;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_RESP} lsu_state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

    localparam logic [31:0] LANE_B_MASK = 32'h0000_00FF;
    localparam logic [31:0] LANE_H_MASK = 32'h0000_FFFF;

    // Stores ignore memop[2]; unknown load codes fall back to a signed byte.
    function automatic lsu_size_e op_size(input logic store, input logic [2:0] op);
        if (store)
            return op[1:0] == MOP_W[1:0] ? SZ_W : op[1:0] == MOP_H[1:0] ? SZ_H : SZ_B;
        return op == MOP_W ? SZ_W : (op == MOP_H || op == MOP_HU) ? SZ_H : SZ_B;
    endfunction

    function automatic logic op_unsigned(input logic [2:0] op);
        return op == MOP_BU || op == MOP_HU;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian load extract/extend and store merge for one
// 32-bit word; purely combinational.
module lsu_lane_align
    import lsu_memop_unit_pkg::*;
(
    input  lsu_size_e   size,
    input  logic        uns,
    input  logic [1:0]  lo,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);
    logic [7:0]  lb;
    logic [15:0] lh;
    logic [31:0] bmask, hmask;

    always_comb begin
        lb = 8'(word >> {lo, 3'b000});
        lh = 16'(word >> {lo[1], 4'b0000});
        bmask = LANE_B_MASK << {lo, 3'b000};
        hmask = LANE_H_MASK << {lo[1], 4'b0000};
        load_data = size == SZ_W ? word :
                    size == SZ_H ? {{16{~uns & lh[15]}}, lh} : {{24{~uns & lb[7]}}, lb};
        merged = size == SZ_W ? wdata :
                 size == SZ_H ? (word & ~hmask) | ({2{wdata[15:0]}} & hmask) :
                                (word & ~bmask) | ({4{wdata[7:0]}} & bmask);
    end

endmodule

// File: rtl/lsu_memop_unit.sv
// lsu_memop_unit: multi-cycle load/store unit for a word-wide SRAM without byte enables.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses on err instead of masking low address bits.
module lsu_memop_unit
    import lsu_memop_unit_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    output logic              ready,
    input  logic              memwr,
    input  logic              memrd,
    input  logic [2:0]        memop,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    localparam int CW = READ_LAT > 1 ? $clog2(READ_LAT) : 1;

    lsu_state_e    state;
    lsu_size_e     size, a_size;
    logic          a_uns, a_store, mis, err_q;
    logic [1:0]    lo;
    logic [31:0]   a_wdata, load_data, merged;
    logic [CW-1:0] wcnt;

    assign size  = op_size(memwr, memop);
    assign ready = state == S_IDLE;
    assign err   = err_q;

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis = (memwr | memrd) & ((size == SZ_H & addr[0]) | (size == SZ_W & addr[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    lsu_lane_align u_align (
        .size      (a_size),
        .uns       (a_uns),
        .lo        (lo),
        .word      (mem_rdata),
        .wdata     (a_wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_size    <= SZ_B;
            a_uns     <= 1'b0;
            a_store   <= 1'b0;
            lo        <= 2'b00;
            a_wdata   <= '0;
            wcnt      <= '0;
            done      <= 1'b0;
            err_q     <= 1'b0;
            rdata     <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                S_IDLE: if (req) begin
                    a_size   <= size;
                    a_uns    <= op_unsigned(memop);
                    a_store  <= memwr;
                    lo       <= addr[1:0];
                    a_wdata  <= wdata;
                    mem_addr <= addr[ADDR_W-1:2];
                    err_q    <= mis;
                    if (mis || !(memwr || memrd)) begin
                        state <= S_RESP;
                        done  <= 1'b1;
                    end else if (memwr && size == SZ_W) begin
                        state     <= S_WRITE;
                        mem_we    <= 1'b1;
                        mem_wdata <= wdata;
                    end else begin
                        state  <= S_READ;
                        mem_re <= 1'b1;
                    end
                end
                S_READ: begin
                    state <= S_WAIT;
                    wcnt  <= '0;
                end
                // The last WAIT cycle is the one in which mem_rdata is valid.
                S_WAIT: if (wcnt == CW'(READ_LAT - 1)) begin
                    if (a_store) begin
                        state     <= S_WRITE;
                        mem_we    <= 1'b1;
                        mem_wdata <= merged;
                    end else begin
                        state <= S_RESP;
                        done  <= 1'b1;
                        rdata <= load_data;
                    end
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
                S_WRITE: begin
                    state <= S_RESP;
                    done  <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    err_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_memop_unit.sv
// tb_lsu_memop_unit: two units (READ_LAT 1 and 3) on private word memories, checked
// against directed vectors and a byte-level reference model under random traffic.
module tb_lsu_memop_unit;
    import lsu_memop_unit_pkg::*;

    typedef struct {
        int          k;
        logic        w, r;
        logic [2:0]  o;
        logic [31:0] a, d, e_rd;
        int          e_lat, e_re, e_we;
        logic        e_er;
        logic [31:0] e_mem;
    } vec_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_v [2];
    logic        memwr, memrd;
    logic [2:0]  memop;
    logic [31:0] addr, wdata;
    logic        ready_v [2], done_v [2], err_v [2], mem_re_v [2], mem_we_v [2];
    logic [31:0] rdata_v [2], mem_wdata_v [2], mem_rdata_v [2];
    logic [29:0] mem_addr_v [2];
    logic [31:0] mem [2][256];
    logic [31:0] pipe [2][3];
    logic [1:0]  bk_we;
    logic [7:0]  bk_a;
    logic [31:0] bk_d;
    int          cyc, tests, fails;
    int          re_n [2], we_n [2];
    logic [31:0] ref_mem [2][256];
    logic [31:0] ref_rd [2];

    always #5 clk = ~clk;

    lsu_memop_unit #(.ADDR_W(32), .READ_LAT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .req(req_v[0]), .ready(ready_v[0]), .memwr(memwr), .memrd(memrd),
        .memop(memop), .addr(addr), .wdata(wdata), .done(done_v[0]), .rdata(rdata_v[0]), .err(err_v[0]),
        .mem_re(mem_re_v[0]), .mem_we(mem_we_v[0]), .mem_addr(mem_addr_v[0]),
        .mem_wdata(mem_wdata_v[0]), .mem_rdata(mem_rdata_v[0]));

    lsu_memop_unit #(.ADDR_W(32), .READ_LAT(3)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req_v[1]), .ready(ready_v[1]), .memwr(memwr), .memrd(memrd),
        .memop(memop), .addr(addr), .wdata(wdata), .done(done_v[1]), .rdata(rdata_v[1]), .err(err_v[1]),
        .mem_re(mem_re_v[1]), .mem_we(mem_we_v[1]), .mem_addr(mem_addr_v[1]),
        .mem_wdata(mem_wdata_v[1]), .mem_rdata(mem_rdata_v[1]));

    // SRAM models: read data appears READ_LAT cycles after the strobe, garbage otherwise.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (bk_we[k]) mem[k][bk_a] <= bk_d;
            if (mem_we_v[k]) mem[k][mem_addr_v[k][7:0]] <= mem_wdata_v[k];
            pipe[k][0] <= mem_re_v[k] ? mem[k][mem_addr_v[k][7:0]] : 32'hBAD0_0000 | 32'(k);
            pipe[k][1] <= pipe[k][0];
            pipe[k][2] <= pipe[k][1];
        end
    end
    assign mem_rdata_v[0] = pipe[0][0];
    assign mem_rdata_v[1] = pipe[1][2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_re_v[k]) re_n[k] <= re_n[k] + 1;
            if (mem_we_v[k]) we_n[k] <= we_n[k] + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", n, act, exp);
        end
    endtask

    function automatic int nbytes(input logic w, input logic [2:0] o);
        if (w) return o[1:0] == 2'b10 ? 4 : o[1:0] == 2'b01 ? 2 : 1;
        return o == 3'b010 ? 4 : (o == 3'b001 || o == 3'b101) ? 2 : 1;
    endfunction

    // Reference: byte-array view of memory, natural-offset alignment, arithmetic sign extension.
    task automatic model(input int k, input logic w, input logic r, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] d, output int lat,
                         output logic [31:0] rd, output logic er, output int nre, output int nwe);
        int n, off, rl;
        logic [31:0] word;
        logic [63:0] v;
        n = nbytes(w, o);
        off = n == 4 ? 0 : n == 2 ? (a[1] ? 2 : 0) : int'(a[1:0]);
        rl = k == 1 ? 3 : 1;
        er = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        er = (w || r) && off != int'(a[1:0]);
`endif
        word = ref_mem[k][a[9:2]];
        nre = 0;
        nwe = 0;
        lat = 1;
        if (!er && w) begin
            for (int i = 0; i < n; i++) word[8*(off+i) +: 8] = d[8*i +: 8];
            ref_mem[k][a[9:2]] = word;
            nwe = 1;
            nre = n == 4 ? 0 : 1;
            lat = n == 4 ? 2 : 3 + rl;
        end else if (!er && r) begin
            v = '0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
            if (!(o == 3'b100 || o == 3'b101) && v[8*n-1]) v = v - (64'd1 << (8*n));
            ref_rd[k] = v[31:0];
            nre = 1;
            lat = 2 + rl;
        end
        rd = ref_rd[k];
    endtask

    task automatic run(input int k, input logic w, input logic r, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] d, output int lat,
                       output logic [31:0] rd, output logic er, output int nre, output int nwe);
        int re0, we0, t0, g;
        @(negedge clk);
        chk("ready_idle", 32'(ready_v[k]), 32'd1);
        memwr = w; memrd = r; memop = o; addr = a; wdata = d; req_v[k] = 1'b1;
        re0 = re_n[k]; we0 = we_n[k]; t0 = cyc;
        @(negedge clk);
        req_v[k] = 1'b0;
        g = 0;
        while (!done_v[k] && g < 40) begin
            @(negedge clk);
            g++;
        end
        lat = done_v[k] ? cyc - t0 : -1;
        rd = rdata_v[k];
        er = err_v[k];
        nre = re_n[k] - re0;
        nwe = we_n[k] - we0;
        if (done_v[k]) begin
            @(negedge clk);
            chk("done_pulse", 32'(done_v[k]), 32'd0);
        end
    endtask

    task automatic cmp(input string t, input int lat, input int e_lat, input logic [31:0] rd,
                       input logic [31:0] e_rd, input logic er, input logic e_er, input int nre,
                       input int e_re, input int nwe, input int e_we, input logic [31:0] m,
                       input logic [31:0] e_m);
        chk({t, "_latency"}, 32'(lat), 32'(e_lat));
        chk({t, "_rdata"}, rd, e_rd);
        chk({t, "_err"}, 32'(er), 32'(e_er));
        chk({t, "_re_count"}, 32'(nre), 32'(e_re));
        chk({t, "_we_count"}, 32'(nwe), 32'(e_we));
        chk({t, "_mem_word"}, m, e_m);
    endtask

    vec_t        tv [12];
    logic [2:0]  st_ops [6];
    int          lat, nre, nwe, mlat, mre, mwe, kk, sel, we0;
    logic [31:0] rd, mrd, aa, dd, fd;
    logic        er, mer, ww, rr;
    logic [2:0]  oo;

    initial begin
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        memwr = 1'b0; memrd = 1'b0; memop = '0; addr = '0; wdata = '0;
        bk_we = '0; bk_a = '0; bk_d = '0;
        tests = 0; fails = 0;
        ref_rd[0] = '0; ref_rd[1] = '0;
        st_ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_ready", 32'(ready_v[k]), 32'd1);
            chk("reset_done", 32'(done_v[k]), 32'd0);
            chk("reset_err", 32'(err_v[k]), 32'd0);
            chk("reset_mem_re", 32'(mem_re_v[k]), 32'd0);
            chk("reset_mem_we", 32'(mem_we_v[k]), 32'd0);
            chk("reset_rdata", rdata_v[k], 32'd0);
            chk("reset_mem_addr", 32'(mem_addr_v[k]), 32'd0);
            chk("reset_mem_wdata", mem_wdata_v[k], 32'd0);
        end
        rst_n = 1'b1;

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 256; i++) begin
                fd = i == 64 ? 32'h8899_AABB : $urandom;
                bk_we = 2'(1 << k); bk_a = 8'(i); bk_d = fd;
                ref_mem[k][i] = fd;
                @(negedge clk);
            end
        end
        bk_we = '0;

        tv[0]  = '{0, 1'b0, 1'b1, 3'b000, 32'h101, 32'h0, 32'hFFFF_FFAA, 3, 1, 0, 1'b0, 32'h8899_AABB};
        tv[1]  = '{0, 1'b0, 1'b1, 3'b101, 32'h102, 32'h0, 32'h0000_8899, 3, 1, 0, 1'b0, 32'h8899_AABB};
        tv[2]  = '{0, 1'b0, 1'b1, 3'b001, 32'h102, 32'h0, 32'hFFFF_8899, 3, 1, 0, 1'b0, 32'h8899_AABB};
        tv[3]  = '{0, 1'b1, 1'b0, 3'b000, 32'h103, 32'h1234_5611, 32'hFFFF_8899, 4, 1, 1, 1'b0, 32'h1199_AABB};
        tv[4]  = '{0, 1'b1, 1'b0, 3'b010, 32'h104, 32'hDEAD_BEEF, 32'hFFFF_8899, 2, 0, 1, 1'b0, 32'hDEAD_BEEF};
        tv[5]  = '{0, 1'b0, 1'b1, 3'b010, 32'h104, 32'h0, 32'hDEAD_BEEF, 3, 1, 0, 1'b0, 32'hDEAD_BEEF};
        tv[6]  = '{0, 1'b0, 1'b0, 3'b010, 32'h104, 32'h5555_5555, 32'hDEAD_BEEF, 1, 0, 0, 1'b0, 32'hDEAD_BEEF};
`ifdef LSU_MISALIGN_TRAP_EN
        tv[7]  = '{0, 1'b0, 1'b1, 3'b010, 32'h102, 32'h0, 32'hDEAD_BEEF, 1, 0, 0, 1'b1, 32'h1199_AABB};
        tv[8]  = '{0, 1'b1, 1'b1, 3'b001, 32'h106, 32'h0000_CAFE, 32'hDEAD_BEEF, 4, 1, 1, 1'b0, 32'hCAFE_BEEF};
`else
        tv[7]  = '{0, 1'b0, 1'b1, 3'b010, 32'h102, 32'h0, 32'h1199_AABB, 3, 1, 0, 1'b0, 32'h1199_AABB};
        tv[8]  = '{0, 1'b1, 1'b1, 3'b001, 32'h106, 32'h0000_CAFE, 32'h1199_AABB, 4, 1, 1, 1'b0, 32'hCAFE_BEEF};
`endif
        tv[9]  = '{1, 1'b0, 1'b1, 3'b000, 32'h101, 32'h0, 32'hFFFF_FFAA, 5, 1, 0, 1'b0, 32'h8899_AABB};
        tv[10] = '{0, 1'b0, 1'b1, 3'b100, 32'h103, 32'h0, 32'h0000_0011, 3, 1, 0, 1'b0, 32'h1199_AABB};
        tv[11] = '{0, 1'b0, 1'b1, 3'b000, 32'h102, 32'h0, 32'hFFFF_FF99, 3, 1, 0, 1'b0, 32'h1199_AABB};

        for (int i = 0; i < 12; i++) begin
            run(tv[i].k, tv[i].w, tv[i].r, tv[i].o, tv[i].a, tv[i].d, lat, rd, er, nre, nwe);
            model(tv[i].k, tv[i].w, tv[i].r, tv[i].o, tv[i].a, tv[i].d, mlat, mrd, mer, mre, mwe);
            cmp($sformatf("vec%0d", i), lat, tv[i].e_lat, rd, tv[i].e_rd, er, tv[i].e_er,
                nre, tv[i].e_re, nwe, tv[i].e_we, mem[tv[i].k][tv[i].a[9:2]], tv[i].e_mem);
        end

        // Reset while a byte store on the READ_LAT=3 unit sits in WAIT.
        @(negedge clk);
        chk("abort_ready_before", 32'(ready_v[1]), 32'd1);
        memwr = 1'b1; memrd = 1'b0; memop = MOP_B; addr = 32'h103; wdata = 32'h1234_5611;
        req_v[1] = 1'b1;
        we0 = we_n[1];
        @(negedge clk);
        req_v[1] = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(ready_v[1]), 32'd1);
        chk("abort_mem_we", 32'(mem_we_v[1]), 32'd0);
        chk("abort_done", 32'(done_v[1]), 32'd0);
        chk("abort_rdata", rdata_v[1], 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_we_count", 32'(we_n[1] - we0), 32'd0);
        chk("abort_mem_word", mem[1][8'h40], 32'h8899_AABB);
        ref_rd[0] = '0;
        ref_rd[1] = '0;

        for (int i = 0; i < 400; i++) begin
            kk = int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 3));
            ww = sel[0];
            rr = sel[1];
            oo = ww ? st_ops[$urandom_range(0, 5)] : 3'($urandom);
            aa = 32'($urandom_range(0, 1023));
            dd = $urandom;
            run(kk, ww, rr, oo, aa, dd, lat, rd, er, nre, nwe);
            model(kk, ww, rr, oo, aa, dd, mlat, mrd, mer, mre, mwe);
            cmp($sformatf("rand%0d_u%0d_w%0d_r%0d_op%0d_a%03h", i, kk, ww, rr, oo, aa),
                lat, mlat, rd, mrd, er, mer, nre, mre, nwe, mwe, mem[kk][aa[9:2]], ref_mem[kk][aa[9:2]]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
